// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam logic [63:0] RESET_VECTOR = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [63:0] align_pc(logic [63:0] pc);
    return pc & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between fetch, instruction memory, execute (redirect) and decode.
interface fetch_unit_if;

  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [63:0] instr_pc_o;

  modport master (
    output imem_req_valid_o, imem_req_addr_o, instr_valid_o, instr_o, instr_pc_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
           redirect_valid_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o, instr_valid_o, instr_o, instr_pc_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
           redirect_valid_i, redirect_pc_i, instr_ready_i
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; used for the instruction buffer and the PC tag queue.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    // NOTE: every signal driven here gets a default first; any path leaving one unassigned would infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; occupancy lives in the pointers/count, so stale words are never presented as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: in-order imem requests under a credit limit, response buffering
// with PC tags, and redirect handling that flushes the buffer and drops stale responses.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] RESET_PC        = RESET_VECTOR,
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic          clk_i,
  input logic          rst_i,
  fetch_unit_if.master bus
);

  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BUF_CW = $clog2(FIFO_DEPTH + 1);

  logic [63:0]       pc_q, pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d, drop_q, drop_d, live;
  logic              redirect, rsp, rsp_drop, rsp_keep, buf_push;
  logic              req_valid, accept, instr_valid, instr_pop;
  fetch_entry_t      buf_in, buf_out;
  logic [BUF_CW-1:0] buf_count;
  logic              buf_full, buf_empty;
  logic [63:0]       tag_pc;
  logic [CNT_W-1:0]  tag_count;
  logic              tag_full, tag_empty;

  assign redirect = bus.redirect_valid_i;
  assign rsp      = bus.imem_rsp_valid_i;
  assign rsp_drop = rsp && (drop_q != '0);
  assign rsp_keep = rsp && !rsp_drop;
  assign buf_push = rsp_keep && !redirect;
  assign live     = outstanding_q - drop_q;

  // Every live request owns a buffer slot, so responses can always be absorbed.
  assign req_valid = !rst_i && !redirect
                  && (32'(buf_count) + 32'(live) < FIFO_DEPTH)
                  && (32'(outstanding_q) < MAX_OUTSTANDING);
  assign accept    = req_valid && bus.imem_req_ready_i;

  assign bus.imem_req_valid_o = req_valid;
  assign bus.imem_req_addr_o  = pc_q;

  assign instr_valid       = !rst_i && !buf_empty;
  assign instr_pop         = instr_valid && bus.instr_ready_i;
  assign bus.instr_valid_o = instr_valid;
  assign bus.instr_o       = instr_valid ? buf_out.instr : '0;
  assign bus.instr_pc_o    = instr_valid ? buf_out.pc : '0;

  assign buf_in = '{pc: tag_pc, instr: bus.imem_rsp_data_i};

  sync_fifo #(.WIDTH(64), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect),
    .push_i  (accept),
    .data_i  (pc_q),
    .pop_i   (rsp_keep),
    .data_o  (tag_pc),
    .count_o (tag_count),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_instr_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect),
    .push_i  (buf_push),
    .data_i  (buf_in),
    .pop_i   (instr_pop),
    .data_o  (buf_out),
    .count_o (buf_count),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(rsp);
    drop_d        = drop_q - CNT_W'(rsp_drop);
    // Redirect wins: everything still in flight after this cycle's response becomes stale.
    if (redirect) begin
      pc_d   = align_pc(bus.redirect_pc_i);
      drop_d = outstanding_d;
    end else if (accept) begin
      pc_d = pc_q + 64'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  a_rsp_without_request: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp |-> (outstanding_q != '0));
  a_buf_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    buf_push |-> !buf_full);
  a_tag_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    accept |-> !tag_full);
  a_tag_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_keep |-> !tag_empty);
  a_tag_tracks_live: assert property (@(posedge clk_i) disable iff (rst_i)
    tag_count == live);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: an imem model answers requests with a PC-derived word,
// and decode-side pops are compared against the program-order PC stream.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned MAX_OUT    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC        (RESET_VECTOR),
    .FIFO_DEPTH      (FIFO_DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(logic [63:0] pc);
    return (pc[33:2] * 32'h9E37_79B1) ^ {2'b00, pc[63:34]} ^ 32'h0000_0013;
  endfunction

  // Reference state: expected decode stream and expected next request address.
  fetch_entry_t exp_q[$];
  logic [63:0]  fill_pc     = RESET_VECTOR;
  logic [63:0]  exp_req_pc  = RESET_VECTOR;

  // imem model state
  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;
  pend_t pend_q[$];
  int    edge_n   = 0;
  int    last_due = 0;
  int    lat_min  = 1;
  int    lat_max  = 1;

  // Values sampled mid-cycle, describing what the next posedge will see.
  logic        s_rst = 1'b1, s_acc = 1'b0, s_rsp = 1'b0, s_redir = 1'b0;
  logic [63:0] s_addr = '0, s_redir_pc = '0;
  int          n_acc = 0;
  int          n_pop = 0;

  task automatic restart(input logic [63:0] pc);
    exp_q.delete();
    fill_pc    = pc;
    exp_req_pc = pc;
  endtask

  // Monitor: compares everything the DUT presents in this cycle.
  always @(negedge clk) begin
    fetch_entry_t e;
    s_rst      = rst;
    s_acc      = bus.imem_req_valid_o && bus.imem_req_ready_i;
    s_addr     = bus.imem_req_addr_o;
    s_rsp      = bus.imem_rsp_valid_i;
    s_redir    = bus.redirect_valid_i;
    s_redir_pc = bus.redirect_pc_i;
    if (!bus.instr_valid_o) begin
      check("idle_instr_zero", bus.instr_o, 64'd0);
      check("idle_pc_zero", bus.instr_pc_o, 64'd0);
    end
    if (rst) begin
      check("reset_req_valid", bus.imem_req_valid_o, 64'd0);
      check("reset_instr_valid", bus.instr_valid_o, 64'd0);
    end else begin
      if (s_acc) begin
        check("req_addr", s_addr, exp_req_pc);
        exp_req_pc = exp_req_pc + 64'd4;
        n_acc++;
      end
      if (s_redir) check("no_req_on_redirect", bus.imem_req_valid_o, 64'd0);
      if (bus.instr_valid_o && bus.instr_ready_i) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", bus.instr_pc_o, e.pc);
          check("instr_word", bus.instr_o, e.instr);
        end
        n_pop++;
      end
    end
  end

  // Reference model + imem: applies what happened at this edge, then drives the next response.
  always @(posedge clk) begin
    int due;
    if (s_rst) begin
      pend_q.delete();
      last_due = 0;
      restart(RESET_VECTOR);
    end else begin
      if (s_rsp && pend_q.size() > 0) void'(pend_q.pop_front());
      if (s_acc) begin
        due = edge_n + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_q.push_back('{addr: s_addr, due: due});
      end
      if (s_redir) restart(align_pc(s_redir_pc));
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: fill_pc, instr: mem_word(fill_pc)});
      fill_pc = fill_pc + 64'd4;
    end
    edge_n++;
    #1;
    if (pend_q.size() > 0 && pend_q[0].due <= edge_n) begin
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rsp_data_i  = mem_word(pend_q[0].addr);
    end else begin
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rsp_data_i  = $urandom;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cycles, a0, found;
    logic [63:0] rp;
    bus.imem_req_ready_i = 1'b1;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = '0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.instr_ready_i    = 1'b1;

    // T1: reset, 1-cycle imem, first-valid latency and in-order stream
    lat_min = 1; lat_max = 1;
    do_reset(3);
    cycles = 1;
    for (int i = 0; i < 10 && !bus.instr_valid_o; i++) begin
      step();
      cycles++;
    end
    check("first_valid_latency", cycles, 64'd3);
    check("first_instr_pc", bus.instr_pc_o, RESET_VECTOR);
    repeat (12) step();

    // T2: decode stalled -> only FIFO_DEPTH requests accepted, issue resumes after a pop
    bus.instr_ready_i = 1'b0;
    do_reset(2);
    a0 = n_acc;
    repeat (10) step();
    check("t2_accepts", n_acc - a0, FIFO_DEPTH);
    check("t2_req_blocked", bus.imem_req_valid_o, 64'd0);
    bus.instr_ready_i = 1'b1;
    step();
    bus.instr_ready_i = 1'b0;
    check("t2_issue_after_pop", bus.imem_req_valid_o, 64'd1);
    bus.instr_ready_i = 1'b1;
    repeat (6) step();

    // T3: redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    do_reset(2);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (pend_q.size() == 2) found = 1;
    end
    check("t3_two_in_flight", found, 64'd1);
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 64'h0000_0000_8000_1002;
    a0 = n_acc;
    step();
    bus.redirect_valid_i = 1'b0;
    check("t3_fifo_empty", bus.instr_valid_o, 64'd0);
    repeat (15) step();
    check("t3_resumed", (n_acc > a0) ? 64'd1 : 64'd0, 64'd1);

    // T4: redirect coinciding with a response and a decode handshake
    lat_min = 1; lat_max = 1;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      step();
      if (bus.imem_rsp_valid_i && bus.instr_valid_o && bus.instr_ready_i) found = 1;
    end
    check("t4_collision_found", found, 64'd1);
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 64'h0000_0000_8000_2000;
    step();
    bus.redirect_valid_i = 1'b0;
    check("t4_fifo_empty", bus.instr_valid_o, 64'd0);
    repeat (10) step();

    // T5: random imem readiness, latency, decode stalls and redirects
    lat_min = 1; lat_max = 3;
    a0 = n_pop;
    for (int i = 0; i < 3000; i++) begin
      bus.imem_req_ready_i = 1'($urandom_range(1, 0));
      bus.instr_ready_i    = 1'($urandom_range(1, 0));
      if ($urandom_range(39, 0) == 0) begin
        rp = 64'h8000_0000 | 64'($urandom & 32'h000F_FFFF);
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = rp;
      end else begin
        bus.redirect_valid_i = 1'b0;
      end
      step();
    end
    bus.redirect_valid_i = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    bus.instr_ready_i    = 1'b1;
    repeat (20) step();
    check("t5_progress", (n_pop - a0 > 300) ? 64'd1 : 64'd0, 64'd1);

    // T6: reset with buffered instruction and a request in flight
    lat_min = 3; lat_max = 3;
    bus.instr_ready_i = 1'b0;
    do_reset(2);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (bus.instr_valid_o && pend_q.size() == 1) found = 1;
    end
    check("t6_state_reached", found, 64'd1);
    do_reset(1);
    check("t6_valid_cleared", bus.instr_valid_o, 64'd0);
    bus.instr_ready_i = 1'b1;
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      step();
      if (bus.instr_valid_o) found = 1;
    end
    check("t6_restart_seen", found, 64'd1);
    check("t6_restart_pc", bus.instr_pc_o, RESET_VECTOR);
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
